// File: rtl/dds_pkg.sv
// Shared widths, quadrant encoding and fold helper for the DDS phase front end.
package dds_pkg;

    localparam int PHASE_W   = 6;
    localparam int QUAD_W    = 2;
    localparam int LUT_DEPTH = 64;

    localparam logic [PHASE_W-1:0] ADDR_MAX = 6'd63;

    typedef enum logic [QUAD_W-1:0] {
        Q0_RISE  = 2'd0,
        Q1_FALL  = 2'd1,
        Q2_NRISE = 2'd2,
        Q3_NFALL = 2'd3
    } quadrant_t;

    // Mirror index inside a quarter wave: (~a + 1) mod 64, so 0 maps to 0.
    function automatic logic [PHASE_W-1:0] twos_neg(input logic [PHASE_W-1:0] a);
        logic [PHASE_W-1:0] r;
        r = ~a + 6'd1;
        return r;
    endfunction

endpackage

// File: rtl/dds_phase_fold_if.sv
// Bundle of enable input and phase/fold outputs shared between the DDS front end and its consumer.
interface dds_phase_fold_if
    import dds_pkg::*;
();

    logic               en;
    logic [PHASE_W-1:0] addr;
    logic [QUAD_W-1:0]  quadrant;
    logic               phase_pos;
    logic               sign_bit;
    logic [PHASE_W-1:0] lut_addr;
    logic               peak;

    modport master (
        output en,
        input  addr,
        input  quadrant,
        input  phase_pos,
        input  sign_bit,
        input  lut_addr,
        input  peak
    );

    modport slave (
        input  en,
        output addr,
        output quadrant,
        output phase_pos,
        output sign_bit,
        output lut_addr,
        output peak
    );

endinterface

// File: rtl/dds_phase_fold_fold.sv
// Quarter-wave fold: mirrors the LUT index in odd quadrants and flags the peak sample.
module quarter_wave_fold
    import dds_pkg::*;
(
    input  logic [PHASE_W-1:0] addr_i,
    input  logic               phase_pos_i,
    output logic [PHASE_W-1:0] lut_addr_o,
    output logic               peak_o
);

    // Mirrored index 0 is the 90/270 degree sample, which the LUT cannot hold.
    always_comb begin
        lut_addr_o = addr_i;
        peak_o     = 1'b0;
        if (phase_pos_i) begin
            lut_addr_o = twos_neg(addr_i);
            peak_o     = ~(|addr_i);
        end else begin
            lut_addr_o = addr_i;
            peak_o     = 1'b0;
        end
    end

endmodule

// File: rtl/dds_phase_fold.sv
// DDS phase accumulator: 6-bit phase counter plus 2-bit quadrant, folded into a quarter-wave LUT address.
module dds_phase_fold
    import dds_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    dds_phase_fold_if.slave   bus
);

    logic [PHASE_W-1:0] addr_d;
    logic [PHASE_W-1:0] addr_q;
    quadrant_t          quad_d;
    quadrant_t          quad_q;

    // Next-state: step the phase when enabled, carrying into the quadrant at 63.
    always_comb begin
        addr_d = addr_q;
        quad_d = quad_q;
        if (bus.en) begin
            addr_d = addr_q + 6'd1;
            if (addr_q == ADDR_MAX) begin
                quad_d = quadrant_t'(quad_q + 2'd1);
            end else begin
                quad_d = quad_q;
            end
        end else begin
            addr_d = addr_q;
            quad_d = quad_q;
        end
    end

    // Phase and quadrant registers; reset clears them immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q <= 6'd0;
            quad_q <= Q0_RISE;
        end else begin
            addr_q <= addr_d;
            quad_q <= quad_d;
        end
    end

    assign bus.addr      = addr_q;
    assign bus.quadrant  = quad_q;
    assign bus.phase_pos = quad_q[0];
    assign bus.sign_bit  = quad_q[1];

    quarter_wave_fold u_fold (
        .addr_i      (addr_q),
        .phase_pos_i (quad_q[0]),
        .lut_addr_o  (bus.lut_addr),
        .peak_o      (bus.peak)
    );

endmodule

// File: tb/tb_dds_phase_fold.sv
// Scoreboard bench for dds_phase_fold against a phase-angle reference model.
module tb_dds_phase_fold;

    logic clk;
    logic rst;

    dds_phase_fold_if bus ();

    dds_phase_fold dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int p_model = 0;          // phase position within the 256-sample period
    int exp_q[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: derive every output from the phase position in the period.
    task automatic check_state(input string tag, input int p);
        int a, q, pp, sb, la, pk;
        a  = p % 64;
        q  = p / 64;
        pp = q % 2;
        sb = q / 2;
        la = (pp == 1) ? ((64 - a) % 64) : a;
        pk = (pp == 1 && a == 0) ? 1 : 0;
        chk({tag, ".addr"},      int'(bus.addr),      a);
        chk({tag, ".quadrant"},  int'(bus.quadrant),  q);
        chk({tag, ".phase_pos"}, int'(bus.phase_pos), pp);
        chk({tag, ".sign_bit"},  int'(bus.sign_bit),  sb);
        chk({tag, ".lut_addr"},  int'(bus.lut_addr),  la);
        chk({tag, ".peak"},      int'(bus.peak),      pk);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            check_state("sb", exp_q.pop_front());
        end
    end

    task automatic step(input logic e);
        bus.en = e;
        @(posedge clk);
        #1;
        if (e) p_model = (p_model + 1) % 256;
        exp_q.push_back(p_model);
    endtask

    task automatic run_en(input int n);
        for (int i = 0; i < n; i++) step(1'b1);
    endtask

    task automatic drain();
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (exp_q.size() != 0) begin
            chk("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    // Asserted between edges: outputs must clear without a clock.
    task automatic do_reset();
        drain();
        rst = 1'b0;
        p_model = 0;
        #1;
        check_state("async_rst", 0);
        #1;
        rst = 1'b1;
    endtask

    int lut_rec[256];
    int pk_cnt;

    initial begin
        rst    = 1'b0;
        bus.en = 1'b0;
        #2;
        check_state("reset", 0);
        #6;
        rst = 1'b1;

        run_en(10);
        drain();
        chk("q0_addr", int'(bus.addr), 10);
        chk("q0_lut",  int'(bus.lut_addr), 10);
        run_en(54);
        drain();
        chk("q1_peak", int'(bus.peak), 1);
        run_en(1);
        drain();
        chk("q1_lut63", int'(bus.lut_addr), 63);
        run_en(68);
        run_en(59);
        drain();
        chk("q3_peak", int'(bus.peak), 1);
        chk("q3_sign", int'(bus.sign_bit), 1);
        run_en(63);
        for (int i = 0; i < 3; i++) step(1'b0);
        step(1'b1);
        drain();
        chk("wrap_quad", int'(bus.quadrant), 0);

        pk_cnt = 0;
        for (int i = 0; i < 256; i++) begin
            step(1'b1);
            lut_rec[i] = int'(bus.lut_addr);
            if (bus.peak) pk_cnt++;
        end
        drain();
        chk("peak_count", pk_cnt, 2);
        for (int i = 0; i < 128; i++) chk("lut_halfwave_sym", lut_rec[i + 128], lut_rec[i]);

        run_en(37);
        drain();
        chk("pre_rst_addr", int'(bus.addr), 37);
        do_reset();
        step(1'b1);
        drain();
        chk("post_rst_addr", int'(bus.addr), 1);

        for (int i = 0; i < 700; i++) begin
            if ($urandom_range(0, 99) == 0) do_reset();
            else step(1'($urandom_range(0, 1)));
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish, expected finish before %0t", $time);
        $fatal(1, "timeout");
    end

endmodule
